// File: rtl/mips_defs.sv
// Shared fetch-path definitions: widths, default reset PC, PC step and the
// buffered fetch entry layout.
package mips_defs;

   localparam int unsigned        INSTR_W      = 32;
   localparam int unsigned        ADDR_W       = 32;
   localparam logic [ADDR_W-1:0]  DEF_RESET_PC = 32'h0000_3000;
   localparam logic [ADDR_W-1:0]  PC_STEP      = 32'd4;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO for fetched instructions: push, pop, flush, count and
// head view; asynchronous active-low reset.
module ifetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd;
   logic [PW-1:0]    wr;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign head = mem[rd];

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr] <= din;
   end

   // Flush outranks a same-cycle push so a response landing on a redirect is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else if (flush) begin
         rd    <= '0;
         wr    <= '0;
         count <= '0;
      end else begin
         if (push)
            wr <= next_ptr(wr);
         if (pop)
            rd <= next_ptr(rd);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   push_into_full: assert property (@(posedge clk) disable iff (!rst)
      !(push && !pop && !flush && count == CW'(DEPTH)));

endmodule

// File: rtl/ifetch_buf.sv
// Instruction fetch stage: owns the fetch PC, issues imem reads and buffers responses for decode.
// Optional IFETCH_STALL_CNT_EN adds stall_cnt, a saturating count of decode-starved cycles.
module ifetch_buf
   import mips_defs::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
   parameter int unsigned       DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redir_valid,
   input  logic [ADDR_W-1:0]  redir_pc,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [INSTR_W-1:0] id_instr,
   output logic [ADDR_W-1:0]  id_pc
`ifdef IFETCH_STALL_CNT_EN
   ,
   output logic [31:0]        stall_cnt
`endif
);

   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned CW1 = CW + 1;

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] pending_pc;
   logic              inflight;
   logic              kill;
   logic              issue;
   logic              push;
   logic              pop;
   logic [CW-1:0]     count;
   logic [CW1-1:0]    credit;
   fetch_entry_t      head;
   fetch_entry_t      din;

   assign id_valid  = (count != '0);
   assign pop       = id_valid & id_ready;
   // Slots already owed: buffered + in flight, minus what decode frees this cycle.
   assign credit    = {1'b0, count} + CW1'(inflight) - CW1'(pop);
   assign issue     = !redir_valid && (credit < CW1'(DEPTH));
   assign imem_req  = issue & rst;
   assign imem_addr = fetch_pc;
   assign push      = inflight & !kill;
   assign din       = '{pc: pending_pc, instr: imem_rdata};
   assign id_instr  = id_valid ? head.instr : '0;
   assign id_pc     = id_valid ? head.pc : '0;

   ifetch_fifo #(
      .WIDTH($bits(fetch_entry_t)),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redir_valid),
      .din   (din),
      .head  (head),
      .count (count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc   <= RESET_PC;
         pending_pc <= '0;
         inflight   <= 1'b0;
         kill       <= 1'b0;
      end else begin
         inflight <= issue;
         kill     <= redir_valid;
         if (redir_valid) begin
            fetch_pc <= word_align(redir_pc);
         end else if (issue) begin
            fetch_pc   <= fetch_pc + PC_STEP;
            pending_pc <= fetch_pc;
         end
      end
   end

`ifdef IFETCH_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cnt <= '0;
      else if (id_ready && !id_valid && !redir_valid && stall_cnt != '1)
         stall_cnt <= stall_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_ifetch_buf.sv
// Directed self-checking bench for ifetch_buf with a fixed-latency tagged instruction memory.
`timescale 1ns/1ps
module tb_ifetch_buf;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        redir_valid = 1'b0;
   logic [31:0] redir_pc = '0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
`ifdef IFETCH_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ifetch_buf #(
      .RESET_PC(32'h0000_3000),
      .DEPTH(2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_instr    (id_instr),
      .id_pc       (id_pc)
`ifdef IFETCH_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   function automatic logic [31:0] tag(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   // Memory answers exactly one cycle after a request.
   always @(posedge clk)
      imem_rdata <= imem_req ? tag(imem_addr) : 32'hDEAD_0000;

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   // Leaves the bench in the first cycle after reset release, outputs settled.
   task automatic do_reset(input logic ready);
      rst = 1'b0;
      redir_valid = 1'b0;
      id_ready = ready;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      #1;
      rst = 1'b0;
      id_ready = 1'b1;
      redir_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      checks++;
      if (imem_req !== 1'b0) begin
         failures++; $display("FAIL reset_req got=%b exp=0", imem_req);
      end
      checks++;
      if (id_valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid got=%b exp=0", id_valid);
      end
      checks++;
      if (id_instr !== 32'h0 || id_pc !== 32'h0) begin
         failures++; $display("FAIL reset_head got=%h/%h exp=0/0", id_instr, id_pc);
      end
`ifdef IFETCH_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 32'd0) begin
         failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt);
      end
`endif
   endtask

   task automatic test_stream();
      logic [31:0] ea;
      logic [31:0] ep;
      do_reset(1'b1);
      for (int k = 0; k < 8; k++) begin
         ea = 32'h3000 + 32'(4 * k);
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== ea) begin
            failures++; $display("FAIL stream_req k=%0d got=%b/%h exp=1/%h", k, imem_req, imem_addr, ea);
         end
         checks++;
         if (k < 2) begin
            if (id_valid !== 1'b0) begin
               failures++; $display("FAIL stream_bubble k=%0d got=%b exp=0", k, id_valid);
            end
         end else begin
            ep = 32'h3000 + 32'(4 * (k - 2));
            if (id_valid !== 1'b1 || id_pc !== ep || id_instr !== tag(ep)) begin
               failures++;
               $display("FAIL stream_out k=%0d got=%b/%h/%h exp=1/%h/%h", k, id_valid, id_pc, id_instr, ep, tag(ep));
            end
         end
`ifdef IFETCH_STALL_CNT_EN
         if (k == 2) begin
            checks++;
            if (stall_cnt !== 32'd2) begin
               failures++; $display("FAIL stream_stall got=%0d exp=2", stall_cnt);
            end
         end
`endif
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] ep;
      do_reset(1'b0);
      for (int k = 0; k < 6; k++) begin
         if (k >= 2) begin
            checks++;
            if (imem_req !== 1'b0) begin
               failures++; $display("FAIL bp_req_low k=%0d got=%b exp=0", k, imem_req);
            end
         end
         if (k < 5) tick();
      end
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h3000) begin
         failures++; $display("FAIL bp_head got=%b/%h exp=1/00003000", id_valid, id_pc);
      end
      tick();
      id_ready = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h3008) begin
         failures++; $display("FAIL bp_resume_req got=%b/%h exp=1/00003008", imem_req, imem_addr);
      end
      for (int j = 0; j < 4; j++) begin
         ep = 32'h3000 + 32'(4 * j);
         checks++;
         if (id_valid !== 1'b1 || id_pc !== ep || id_instr !== tag(ep)) begin
            failures++; $display("FAIL bp_drain j=%0d got=%b/%h exp=1/%h", j, id_valid, id_pc, ep);
         end
         tick();
      end
   endtask

   task automatic test_redirect();
      do_reset(1'b1);
      repeat (4) tick();
      checks++;
      if (id_pc !== 32'h3008) begin
         failures++; $display("FAIL redir_pre got=%h exp=00003008", id_pc);
      end
      redir_valid = 1'b1;
      redir_pc = 32'h3100;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         failures++; $display("FAIL redir_noissue got=%b exp=0", imem_req);
      end
      tick();
      redir_valid = 1'b0;
      #1;
      checks++;
      if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3100) begin
         failures++; $display("FAIL redir_t1 got=%b/%b/%h exp=0/1/00003100", id_valid, imem_req, imem_addr);
      end
      tick();
      checks++;
      if (id_valid !== 1'b0) begin
         failures++; $display("FAIL redir_t2 got=%b/%h exp=0", id_valid, id_pc);
      end
      tick();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h3100 || id_instr !== tag(32'h3100)) begin
         failures++; $display("FAIL redir_t3 got=%b/%h exp=1/00003100", id_valid, id_pc);
      end
      tick();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h3104) begin
         failures++; $display("FAIL redir_t4 got=%b/%h exp=1/00003104", id_valid, id_pc);
      end
   endtask

   task automatic test_redirect_pop();
      logic [31:0] got[$];
      logic [31:0] exp_q[5];
      exp_q = '{32'h3000, 32'h3004, 32'h3200, 32'h3204, 32'h3208};
      do_reset(1'b1);
      for (int k = 0; k < 9; k++) begin
         if (k == 3) begin
            redir_valid = 1'b1;
            redir_pc = 32'h3200;
            #1;
         end
         if (k == 4) begin
            redir_valid = 1'b0;
            #1;
         end
         if (id_valid === 1'b1 && id_ready === 1'b1) got.push_back(id_pc);
         tick();
      end
      checks++;
      if (got.size() != 5) begin
         failures++; $display("FAIL rpop_count got=%0d exp=5", got.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
               failures++; $display("FAIL rpop_seq i=%0d got=%h exp=%h", i, got[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_align_wrap();
      do_reset(1'b1);
      repeat (3) tick();
      redir_valid = 1'b1;
      redir_pc = 32'h3102;
      #1;
      tick();
      redir_valid = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h3100) begin
         failures++; $display("FAIL align_addr got=%b/%h exp=1/00003100", imem_req, imem_addr);
      end
      repeat (2) tick();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h3100) begin
         failures++; $display("FAIL align_out got=%b/%h exp=1/00003100", id_valid, id_pc);
      end
      redir_valid = 1'b1;
      redir_pc = 32'hFFFF_FFFC;
      #1;
      tick();
      redir_valid = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
         failures++; $display("FAIL wrap_addr0 got=%b/%h exp=1/fffffffc", imem_req, imem_addr);
      end
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         failures++; $display("FAIL wrap_addr1 got=%b/%h exp=1/00000000", imem_req, imem_addr);
      end
      tick();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_instr !== tag(32'hFFFF_FFFC)) begin
         failures++; $display("FAIL wrap_out0 got=%b/%h exp=1/fffffffc", id_valid, id_pc);
      end
      tick();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== tag(32'h0)) begin
         failures++; $display("FAIL wrap_out1 got=%b/%h/%h exp=1/00000000/%h", id_valid, id_pc, id_instr, tag(32'h0));
      end
   endtask

   task automatic test_back_to_back();
      do_reset(1'b1);
      repeat (3) tick();
      redir_valid = 1'b1;
      redir_pc = 32'h4000;
      #1;
      tick();
      redir_pc = 32'h5000;
      #1;
      checks++;
      if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
         failures++; $display("FAIL b2b_mid got=%b/%b exp=0/0", imem_req, id_valid);
      end
      tick();
      redir_valid = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h5000) begin
         failures++; $display("FAIL b2b_addr got=%b/%h exp=1/00005000", imem_req, imem_addr);
      end
      tick();
      checks++;
      if (id_valid !== 1'b0) begin
         failures++; $display("FAIL b2b_gap got=%b/%h exp=0", id_valid, id_pc);
      end
      tick();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h5000) begin
         failures++; $display("FAIL b2b_out got=%b/%h exp=1/00005000", id_valid, id_pc);
      end
   endtask

   task automatic test_reset_mid();
      do_reset(1'b1);
      repeat (3) tick();
      checks++;
      if (id_valid !== 1'b1 || imem_req !== 1'b1) begin
         failures++; $display("FAIL rmid_pre got=%b/%b exp=1/1", id_valid, imem_req);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (id_valid !== 1'b0 || imem_req !== 1'b0) begin
         failures++; $display("FAIL rmid_drop got=%b/%b exp=0/0", id_valid, imem_req);
      end
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin
         failures++; $display("FAIL rmid_restart got=%b/%h exp=1/00003000", imem_req, imem_addr);
      end
`ifdef IFETCH_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 32'd0) begin
         failures++; $display("FAIL rmid_stall0 got=%0d exp=0", stall_cnt);
      end
`endif
      repeat (2) tick();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'h3000) begin
         failures++; $display("FAIL rmid_out got=%b/%h exp=1/00003000", id_valid, id_pc);
      end
`ifdef IFETCH_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 32'd2) begin
         failures++; $display("FAIL rmid_stall2 got=%0d exp=2", stall_cnt);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_pop();
      test_align_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
